// File: rtl/bf_board_pkg.sv
// Shared types and defaults for the bf board control front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bf_board_pkg;

    typedef enum logic [0:0] {
        MODE_MANUAL = 1'b0,
        MODE_RUN    = 1'b1
    } mode_t;

    localparam int DEF_STEP_KEY        = 1;
    localparam int DEF_PAGE_KEY        = 2;
    localparam int DEF_RUN_KEY         = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;

    // Index width for a channel selector; a single channel still needs one bit.
    function automatic int page_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, press pulse.
// Latency: 2 sync + DEBOUNCE_CYCLES to level, +1 to pulse.
// Backpressure: none; free-running, pulse is a one-cycle strobe.
module key_debounce
    import bf_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync    <= {sync[0], ~key_n};
            level_d <= level;
            pulse   <= level & ~level_d;
            // Any return to the current level restarts the stability count.
            if (sync[1] != level) begin
                if (cnt == CNT_MAX) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bf_board_ctrl.sv
// Board control front end: debounced keys, manual/auto step strobe, display page select.
// Latency: step 1 cycle after STEP key pulse; auto-run step every run_rate cycles. Optional BF_BREAKPOINT_EN.
// Backpressure: none; step is a fire-and-forget one-cycle strobe.
module bf_board_ctrl
    import bf_board_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CHANNELS        = 3,
    parameter int CH_WIDTH        = 8,
    parameter int RATE_WIDTH      = 26,
    parameter int STEP_KEY        = DEF_STEP_KEY,
    parameter int PAGE_KEY        = DEF_PAGE_KEY,
    parameter int RUN_KEY         = DEF_RUN_KEY,
`ifdef BF_BREAKPOINT_EN
    parameter int BP_CHANNEL      = 1,
`endif
    localparam int PAGE_W         = page_width(CHANNELS)
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_KEYS-1:0]          key_n,
    input  logic [CHANNELS*CH_WIDTH-1:0] ch_data,
    input  logic [RATE_WIDTH-1:0]        run_rate,
`ifdef BF_BREAKPOINT_EN
    input  logic [CH_WIDTH-1:0]          bp_addr,
    input  logic                         bp_enable,
    output logic                         bp_hit,
`endif
    output logic [NUM_KEYS-1:0]          key_level,
    output logic [NUM_KEYS-1:0]          key_pulse,
    output logic                         step,
    output logic                         running,
    output logic [PAGE_W-1:0]            page,
    output logic [CH_WIDTH-1:0]          disp_value
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clock (clock),
            .resetn(resetn),
            .key_n (key_n[k]),
            .level (key_level[k]),
            .pulse (key_pulse[k])
        );
    end

    mode_t                 state;
    logic [RATE_WIDTH-1:0] rate_cnt;
    logic [RATE_WIDTH-1:0] period_m1;
    logic                  run_pulse;
    logic                  step_pulse;
    logic                  page_pulse;
    logic                  wrap;
    logic                  run_step;
    logic                  bp_stop;

    assign run_pulse  = key_pulse[RUN_KEY];
    assign step_pulse = key_pulse[STEP_KEY];
    assign page_pulse = key_pulse[PAGE_KEY];
    assign period_m1  = (run_rate == '0) ? '0 : run_rate - 1'b1;
    // >= rather than == so a shrunken period wraps on the very next cycle.
    assign wrap       = (state == MODE_RUN) && (rate_cnt >= period_m1);
    assign run_step   = wrap && !run_pulse;
    assign running    = (state == MODE_RUN);
    assign disp_value = ch_data[page*CH_WIDTH +: CH_WIDTH];

`ifdef BF_BREAKPOINT_EN
    logic first_step;

    assign bp_stop = run_step && bp_enable && !first_step &&
                     (ch_data[BP_CHANNEL*CH_WIDTH +: CH_WIDTH] == bp_addr);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            first_step <= 1'b0;
            bp_hit     <= 1'b0;
        end else begin
            // The first step after entering RUN may sit on the breakpoint itself.
            if (run_pulse && state == MODE_MANUAL) begin
                first_step <= 1'b1;
            end else if (run_step) begin
                first_step <= 1'b0;
            end
            if (bp_stop) begin
                bp_hit <= 1'b1;
            end else if (run_pulse || step_pulse) begin
                bp_hit <= 1'b0;
            end
        end
    end
`else
    assign bp_stop = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= MODE_MANUAL;
            rate_cnt <= '0;
            step     <= 1'b0;
            page     <= '0;
        end else begin
            if (state == MODE_MANUAL) begin
                step <= step_pulse && !run_pulse;
            end else begin
                step <= run_step && !bp_stop;
            end

            if (run_pulse || bp_stop) begin
                state    <= (state == MODE_RUN) ? MODE_MANUAL : MODE_RUN;
                rate_cnt <= '0;
            end else if (state == MODE_RUN) begin
                rate_cnt <= wrap ? '0 : rate_cnt + 1'b1;
            end

            if (page_pulse) begin
                page <= (page == PAGE_W'(CHANNELS - 1)) ? '0 : page + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bf_board_ctrl.sv
// Scoreboarded bench for bf_board_ctrl with a short debounce and 8-bit rate.
// Expected step/key-pulse cycles are queued at stimulus time and matched as the DUT emits them.
`timescale 1ns/1ps
module tb_bf_board_ctrl;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  key_n;
    logic [23:0] ch_data;
    logic [7:0]  run_rate;
    logic [3:0]  key_level;
    logic [3:0]  key_pulse;
    logic        step;
    logic        running;
    logic [1:0]  page;
    logic [7:0]  disp_value;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

`ifdef BF_BREAKPOINT_EN
    logic [7:0] bp_addr;
    logic       bp_enable;
    logic       bp_hit;
    logic       bp_mode;
    logic [7:0] pc;
    always @(posedge clock) if (bp_mode && step) pc <= pc + 8'd1;
    assign ch_data = {8'h33, bp_mode ? pc : 8'h22, 8'h11};
`else
    assign ch_data = {8'h33, 8'h22, 8'h11};
`endif

    bf_board_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RATE_WIDTH     (8)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .key_n     (key_n),
        .ch_data   (ch_data),
        .run_rate  (run_rate),
`ifdef BF_BREAKPOINT_EN
        .bp_addr   (bp_addr),
        .bp_enable (bp_enable),
        .bp_hit    (bp_hit),
`endif
        .key_level (key_level),
        .key_pulse (key_pulse),
        .step      (step),
        .running   (running),
        .page      (page),
        .disp_value(disp_value)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int exp_step[$];
    int exp_pulse[$];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Scoreboard: every step/key pulse must match the head of its queue.
    always @(negedge clock) begin
        if (resetn) begin
            if (step) begin
                if (exp_step.size() == 0) check("step_unexpected", cyc, -1);
                else check("step_cycle", cyc, exp_step.pop_front());
            end
            for (int k = 0; k < 4; k++) begin
                if (key_pulse[k]) begin
                    if (exp_pulse.size() == 0) check("pulse_unexpected", cyc * 8 + k, -1);
                    else check("pulse_cycle_key", cyc * 8 + k, exp_pulse.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic press(input int k, input bit with_step);
        int c;
        c = cyc;
        key_n[k] = 1'b0;
        exp_pulse.push_back((c + 7) * 8 + k);
        if (with_step) exp_step.push_back(c + 8);
        tick(8);
        key_n[k] = 1'b1;
        tick(8);
    endtask

    initial begin
        int c;
        int d;
        resetn   = 1'b0;
        key_n    = 4'hF;
        run_rate = 8'd5;
`ifdef BF_BREAKPOINT_EN
        bp_addr   = 8'h05;
        bp_enable = 1'b0;
        bp_mode   = 1'b0;
        pc        = 8'h00;
`endif
        #12;
        check("rst_key_level", int'(key_level), 0);
        check("rst_key_pulse", int'(key_pulse), 0);
        check("rst_step", int'(step), 0);
        check("rst_running", int'(running), 0);
        check("rst_page", int'(page), 0);
`ifdef BF_BREAKPOINT_EN
        check("rst_bp_hit", int'(bp_hit), 0);
`endif
        @(posedge clock);
        #1 resetn = 1'b1;
        tick(2);

        // Bounce shorter than the debounce window, then a stable press.
        for (int i = 0; i < 4; i++) begin
            key_n[1] = (i % 2 == 1);
            tick(2);
        end
        key_n[1] = 1'b1;
        tick(2);
        c = cyc;
        key_n[1] = 1'b0;
        exp_pulse.push_back((c + 7) * 8 + 1);
        exp_step.push_back(c + 8);
        tick(10);
        check("bounce_level", int'(key_level[1]), 1);
        key_n[1] = 1'b1;
        tick(10);
        check("bounce_release", int'(key_level[1]), 0);

        // Page wrap across three channels.
        check("page0", int'(page), 0);
        check("disp0", int'(disp_value), 'h11);
        press(2, 1'b0);
        check("page1", int'(page), 1);
        check("disp1", int'(disp_value), 'h22);
        press(2, 1'b0);
        check("page2", int'(page), 2);
        check("disp2", int'(disp_value), 'h33);
        press(2, 1'b0);
        check("page_wrap", int'(page), 0);
        check("disp_wrap", int'(disp_value), 'h11);

        // Auto-run at period 5; STEP presses in RUN add nothing.
        run_rate = 8'd5;
        c = cyc;
        for (int j = 0; j < 10; j++) exp_step.push_back(c + 13 + 5 * j);
        press(3, 1'b0);
        check("run_on", int'(running), 1);
        press(1, 1'b0);
        press(1, 1'b0);
        wait_to(c + 53);
        press(3, 1'b0);
        check("run_off", int'(running), 0);
        tick(30);

        // Period 0 behaves as 1: a step every cycle.
        run_rate = 8'd0;
        c = cyc;
        for (int j = 9; j <= 27; j++) exp_step.push_back(c + j);
        press(3, 1'b0);
        check("rate0_on", int'(running), 1);
        wait_to(c + 20);
        press(3, 1'b0);
        check("rate0_off", int'(running), 0);
        tick(5);

        // Async reset while running on page 2.
        press(2, 1'b0);
        press(2, 1'b0);
        check("pre_rst_page", int'(page), 2);
        run_rate = 8'd5;
        c = cyc;
        exp_step.push_back(c + 13);
        exp_step.push_back(c + 18);
        press(3, 1'b0);
        wait_to(c + 17);
        check("pre_rst_running", int'(running), 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_step", int'(step), 0);
        check("arst_running", int'(running), 0);
        check("arst_page", int'(page), 0);
        check("arst_disp", int'(disp_value), 'h11);
        check("arst_key_level", int'(key_level), 0);
        while (exp_step.size() > 0 && exp_step[$] > cyc) void'(exp_step.pop_back());
        tick(3);
        resetn = 1'b1;
        tick(10);

`ifdef BF_BREAKPOINT_EN
        // Breakpoint at pc 05, then resume past it.
        bp_mode   = 1'b1;
        bp_enable = 1'b1;
        run_rate  = 8'd5;
        c = cyc;
        for (int j = 0; j < 5; j++) exp_step.push_back(c + 13 + 5 * j);
        press(3, 1'b0);
        wait_to(c + 45);
        check("bp_running", int'(running), 0);
        check("bp_hit", int'(bp_hit), 1);
        check("bp_pc", int'(pc), 5);
        d = cyc;
        exp_step.push_back(d + 13);
        exp_step.push_back(d + 18);
        exp_step.push_back(d + 23);
        press(3, 1'b0);
        check("bp_clear", int'(bp_hit), 0);
        check("bp_resume_running", int'(running), 1);
        check("bp_resume_pc", int'(pc), 6);
        wait_to(d + 20);
        press(3, 1'b0);
        check("bp_end_pc", int'(pc), 8);
        bp_enable = 1'b0;
        bp_mode   = 1'b0;
        tick(5);
`endif
        d = cyc;
        tick(20);
        check("step_queue_drained", exp_step.size(), 0);
        check("pulse_queue_drained", exp_pulse.size(), 0);
        check("final_cycle_budget", int'(cyc < 90000), 1);
        if (d < 0) $display("cycle %0d", d);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bf_board_ctrl.md
Name: bf_board_ctrl

Overview:
- Board-level control front end for the bf machine.
- Replaces the raw push-button clocking with debounced, synchronised key handling on the 50 MHz clock.
- Generates single-cycle step pulses, either manual or auto-run at a programmable rate.
- Selects which machine channel (data, pc, dp, ...) is routed to the display digits. Hex encoding stays in the existing hex module, downstream.

Parameters:
- NUM_KEYS, 4, number of raw active-low push-buttons.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a key change (10 ms at 50 MHz).
- CHANNELS, 3, number of displayable channels (min 1).
- CH_WIDTH, 8, bits per channel.
- RATE_WIDTH, 26, width of the auto-run period value.
- STEP_KEY, 1, key index for manual step.
- PAGE_KEY, 2, key index for page advance.
- RUN_KEY, 3, key index for run/stop toggle.

Ports:
- clock, input, 1, system clock (CLOCK_50).
- resetn, input, 1, asynchronous active-low reset.
- key_n, input, NUM_KEYS, raw asynchronous buttons, 0 = pressed.
- ch_data, input, CHANNELS*CH_WIDTH, channel i at bits [i*CH_WIDTH +: CH_WIDTH].
- run_rate, input, RATE_WIDTH, auto-run period in cycles (0 is treated as 1).
- key_level, output, NUM_KEYS, debounced pressed level, 1 = pressed.
- key_pulse, output, NUM_KEYS, one-cycle pulse on each accepted press.
- step, output, 1, one-cycle machine step strobe.
- running, output, 1, 1 = auto-run mode.
- page, output, $clog2(CHANNELS) (min 1), selected channel index.
- disp_value, output, CH_WIDTH, ch_data slice for the current page (combinational from page).

Behaviour:
- Reset (async, resetn=0):
  - key_level=0, key_pulse=0, step=0, running=0, page=0.
  - Sync flops cleared to "released"; debounce and rate counters 0.
- Key path, per key:
  - 2-flop synchroniser on ~key_n.
  - Counter increments while the synced sample differs from key_level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, key_level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- key_pulse[k] is high for exactly the one cycle after key_level[k] rises 0->1. Releases produce no pulse.
- Latency from stable pressed input to key_pulse: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Mode FSM, states MANUAL and RUN:
  - MANUAL->RUN on key_pulse[RUN_KEY].
  - RUN->MANUAL on key_pulse[RUN_KEY].
  - Each transition clears the rate counter. running = (state==RUN).
- Stepping:
  - MANUAL: step = key_pulse[STEP_KEY] registered, 1 cycle later.
  - RUN:
    - The rate counter counts 0..P-1, with P = (run_rate==0) ? 1 : run_rate.
    - step pulses on the cycle the counter wraps, so the first step comes P cycles after entering RUN.
    - STEP_KEY is ignored.
    - A change to run_rate takes effect at the next wrap. If the counter is already >= the new P-1, it wraps on the next cycle.
- Page:
  - key_pulse[PAGE_KEY] advances page by 1, wrapping from CHANNELS-1 to 0.
  - With CHANNELS=1, page stays 0.
  - Page changes in both modes.
- Simultaneous pulses in the same cycle are all honoured independently. Example: RUN and STEP in MANUAL means enter RUN and no manual step.
- Reset mid-run returns to MANUAL, page 0, and any pending step is dropped.

Optional Feature:
- Macro: BF_BREAKPOINT_EN.
- When defined:
  - Adds parameter BP_CHANNEL (default 1, the pc channel).
  - Adds input bp_addr [CH_WIDTH] and input bp_enable [1].
  - Adds output bp_hit [1].
  - In RUN, on a cycle where a step would issue and bp_enable=1 and ch_data[BP_CHANNEL]==bp_addr, the step is suppressed, state -> MANUAL and bp_hit set to 1.
  - The first step after entering RUN is exempt, so run can resume from a breakpoint.
  - bp_hit clears on the next key_pulse[RUN_KEY] or key_pulse[STEP_KEY]. Reset value 0.
- When not defined: the ports and logic are absent, and behaviour is as above.

Decomposition:
- Package bf_board_pkg holds:
  - mode_t enum {MODE_MANUAL, MODE_RUN};
  - default key index constants;
  - the DEBOUNCE_CYCLES default.
- Sub-module key_debounce (synchroniser + counter + rise pulse, parameter DEBOUNCE_CYCLES), instantiated NUM_KEYS times via generate.

Test Plan (bench uses DEBOUNCE_CYCLES=4, RATE_WIDTH=8):
- Bounce: key_n[1] toggles every 2 cycles for 10 cycles, then is held 0 -> exactly one key_pulse[1] and one step, 7 cycles after the stable point; no earlier pulse.
- Page wrap, CHANNELS=3, ch_data={8'h33,8'h22,8'h11}: three PAGE presses -> page 1,2,0; disp_value 22,33,11.
- Auto-run, run_rate=5: RUN press -> running=1, step every 5 cycles; STEP presses produce no extra steps; second RUN press -> running=0, no further steps.
- run_rate=0 in RUN -> step high every cycle.
- Async reset: resetn low mid-RUN on page 2 -> outputs 0, running=0, page=0 immediately, without waiting for a clock edge.
- BF_BREAKPOINT_EN, bp_addr=8'h05, bp_enable=1, pc increments on each step from 0: RUN -> steps stop with pc=05, bp_hit=1, running=0; RUN again -> one step exempt, pc=06, run continues.
